// File: rtl/cpu_mu0_multicycle.sv
// MU0-style accumulator CPU: multicycle FETCH/DECODE/MEM/HALT controller driving a single
// shared instruction/data bus with a slave waitrequest stall.
module cpu_mu0_multicycle #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_waitrequest,
  output logic              running,
  output logic              err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STO = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JGE = 4'b0101;
  localparam logic [3:0] OP_JNE = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1000;
  localparam logic [3:0] OP_LDI = 4'b1001;

  typedef enum logic [1:0] {FETCH, DECODE, MEM, HALT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic              err_reg, err_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              transfer;

  assign opcode   = ir_reg[DATA_W-1:DATA_W-4];
  assign operand  = ir_reg[ADDR_W-1:0];
  assign transfer = !mem_waitrequest;

  // Bus controls depend only on state and IR so they stay frozen during a stall.
  assign mem_read  = (state_reg == FETCH) || ((state_reg == MEM) && (opcode != OP_STO));
  assign mem_write = (state_reg == MEM) && (opcode == OP_STO);
  assign mem_addr  = (state_reg == MEM) ? operand : pc_reg;
  assign mem_wdata = acc_reg;

  assign running   = (state_reg != HALT);
  assign err       = err_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign pc        = pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC_V;
      acc_reg       <= '0;
      ir_reg        <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      acc_reg       <= acc_next;
      ir_reg        <= ir_next;
      err_reg       <= err_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    acc_next       = acc_reg;
    ir_next        = ir_reg;
    err_next       = err_reg;
    out_valid_next = 1'b0;
    out_data_next  = out_data_reg;
    unique case (state_reg)
      FETCH: begin
        if (transfer) begin
          ir_next    = mem_rdata;
          pc_next    = pc_reg + 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = FETCH;
        case (opcode)
          OP_LDA, OP_STO, OP_ADD, OP_SUB: state_next = MEM;
          OP_JMP: pc_next = operand;
          OP_JGE: if (!acc_reg[DATA_W-1]) pc_next = operand;
          OP_JNE: if (acc_reg != '0) pc_next = operand;
          OP_OUT: begin
            out_valid_next = 1'b1;
            out_data_next  = acc_reg;
          end
          OP_LDI: acc_next = {{(DATA_W-ADDR_W){1'b0}}, operand};
          OP_STP: state_next = HALT;
          default: begin
            err_next   = 1'b1;
            state_next = HALT;
          end
        endcase
      end
      MEM: begin
        if (transfer) begin
          case (opcode)
            OP_LDA:  acc_next = mem_rdata;
            OP_ADD:  acc_next = acc_reg + mem_rdata;
            OP_SUB:  acc_next = acc_reg - mem_rdata;
            default: acc_next = acc_reg;
          endcase
          state_next = FETCH;
        end
      end
      HALT: state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_mu0_multicycle.sv
// Directed-program bench for cpu_mu0_multicycle: a bench-side memory feeds small programs,
// a write/OUT log records bus activity, and one checking task compares against hand values.
module tb_cpu_mu0_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic        clr_log = 1'b0;
  logic        waitreq = 1'b0;
  logic        waitreq2 = 1'b0;

  logic [11:0] mem_addr, mem_addr2;
  logic        mem_read, mem_read2, mem_write, mem_write2;
  logic [15:0] mem_wdata, mem_wdata2, mem_rdata, mem_rdata2;
  logic        running, running2, err, err2, out_valid, out_valid2;
  logic [15:0] out_data, out_data2;
  logic [11:0] pc, pc2;

  logic [15:0] mem [0:4095];

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_count, out_count;
  logic [11:0] last_wr_addr;
  logic [15:0] last_wr_data, last_out;

  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata2 = mem[mem_addr2];

  cpu_mu0_multicycle dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_waitrequest(waitreq),
    .running(running), .err(err), .out_valid(out_valid), .out_data(out_data), .pc(pc)
  );

  cpu_mu0_multicycle #(.RESET_PC(12'hFFF)) dut2 (
    .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_read(mem_read2), .mem_write(mem_write2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_waitrequest(waitreq2),
    .running(running2), .err(err2), .out_valid(out_valid2), .out_data(out_data2), .pc(pc2)
  );

  // Bus log: completed writes and cycles with out_valid high
  always @(posedge clk) begin
    if (clr_log) begin
      wr_count = 0;
      out_count = 0;
      last_wr_addr = '0;
      last_wr_data = '0;
      last_out = '0;
    end else begin
      if (mem_write && !waitreq) begin
        wr_count++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
      if (out_valid) begin
        out_count++;
        last_out = out_data;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr_log = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clr_log = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int n);
    n = 0;
    while (running && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;

  initial begin
    // Basic LDA/ADD/STO/STP program
    clear_mem();
    mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012; mem[3] = 16'h7000;
    mem[12'h010] = 16'h0005; mem[12'h011] = 16'h0003;
    do_reset();
    check("rst_pc", pc, 12'h000);
    check("rst_running", running, 1);
    check("rst_err", err, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_fetch_strobes", {mem_read, mem_write}, 2'b10);
    check("rst_fetch_addr", mem_addr, 12'h000);
    run_to_halt(100, n);
    check("p1_halted", running, 0);
    check("p1_cycles", n, 11);
    check("p1_wr_count", wr_count, 1);
    check("p1_wr_addr", last_wr_addr, 12'h012);
    check("p1_wr_data", last_wr_data, 16'h0008);
    check("p1_pc", pc, 12'h004);
    check("p1_err", err, 0);
    check("halt_strobes", {mem_read, mem_write}, 2'b00);

    // Same program, first fetch stalled three cycles
    do_reset();
    waitreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_addr", mem_addr, 12'h000);
      check("stall_strobes", {mem_read, mem_write}, 2'b10);
      check("stall_pc", pc, 12'h000);
    end
    waitreq = 1'b0;
    run_to_halt(100, n);
    check("stall_cycles_after", n, 11);
    check("stall_wr_data", last_wr_data, 16'h0008);
    check("stall_pc_end", pc, 12'h004);

    // JGE not taken on negative acc, then taken on zero
    clear_mem();
    mem[0] = 16'h9800; mem[1] = 16'h3010; mem[2] = 16'h5020; mem[3] = 16'h8000;
    mem[4] = 16'h9000; mem[5] = 16'h5020; mem[6] = 16'hF000;
    mem[12'h020] = 16'h8000; mem[12'h021] = 16'h7000;
    mem[12'h010] = 16'h1000;
    do_reset();
    run_to_halt(200, n);
    check("jge_halted", running, 0);
    check("jge_out_cycles", out_count, 2);
    check("jge_last_out", last_out, 16'h0000);
    check("jge_pc", pc, 12'h022);
    check("jge_err", err, 0);

    // SUB wrap with OUT pulse timing; first OUT of the JGE program shows acc=0xF800
    clear_mem();
    mem[0] = 16'h9FFF; mem[1] = 16'h3010; mem[2] = 16'h8000; mem[3] = 16'h7000;
    mem[12'h010] = 16'h0001;
    do_reset();
    repeat (6) @(negedge clk);
    check("out_before", out_valid, 0);
    @(negedge clk);
    check("out_pulse", out_valid, 1);
    check("out_data", out_data, 16'h0FFE);
    @(negedge clk);
    check("out_after", out_valid, 0);
    check("out_hold", out_data, 16'h0FFE);
    run_to_halt(100, n);
    check("out_count", out_count, 1);

    // JNE countdown loop 3->0, then OUT of zero
    clear_mem();
    mem[0] = 16'h9003; mem[1] = 16'h3010; mem[2] = 16'h6001; mem[3] = 16'h8000; mem[4] = 16'h7000;
    mem[12'h010] = 16'h0001;
    do_reset();
    run_to_halt(200, n);
    check("jne_cycles", n, 21);
    check("jne_pc", pc, 12'h005);
    check("jne_out", last_out, 16'h0000);

    // JMP forward; skipped word would raise err
    clear_mem();
    mem[0] = 16'h9042; mem[1] = 16'h4100; mem[2] = 16'hF000;
    mem[12'h100] = 16'h8000; mem[12'h101] = 16'h7000;
    do_reset();
    run_to_halt(100, n);
    check("jmp_pc", pc, 12'h102);
    check("jmp_out", last_out, 16'h0042);
    check("jmp_err", err, 0);

    // PC wrap from RESET_PC=0xFFF on the second instance
    clear_mem();
    mem[12'hFFF] = 16'h9001; mem[0] = 16'h8000; mem[1] = 16'h7000;
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    check("wrap_rst_pc", pc2, 12'hFFF);
    check("wrap_fetch_addr", mem_addr2, 12'hFFF);
    @(negedge clk);
    check("wrap_pc", pc2, 12'h000);
    n = 1;
    while (running2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wrap_cycles", n, 6);
    check("wrap_out", out_data2, 16'h0001);
    check("wrap_pc_end", pc2, 12'h002);

    // Undefined opcode halts with err and no further strobes
    clear_mem();
    mem[0] = 16'hA000;
    do_reset();
    run_to_halt(100, n);
    check("err_cycles", n, 2);
    check("err_flag", err, 1);
    check("err_running", running, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_no_strobes", {mem_read, mem_write}, 2'b00);
    end
    check("err_sticky", err, 1);

    // Reset while a STO is stalled in MEM abandons the write
    clear_mem();
    mem[0] = 16'h1012;
    do_reset();
    repeat (2) @(negedge clk);
    waitreq = 1'b1;
    check("sto_write", {mem_read, mem_write}, 2'b01);
    check("sto_addr", mem_addr, 12'h012);
    @(negedge clk);
    check("sto_write_held", {mem_read, mem_write}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_strobes", {mem_read, mem_write}, 2'b10);
    check("abort_addr", mem_addr, 12'h000);
    check("abort_err", err, 0);
    check("abort_no_write", wr_count, 0);
    waitreq = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_mu0_multicycle.md
CPU_MU0_MULTICYCLE -- requirements
Module: cpu_mu0_multicycle

Interface
REQ-001 Parameter DATA_W, default 16: accumulator, memory word and instruction width; DATA_W SHALL be >= ADDR_W+4.
REQ-002 Parameter ADDR_W, default 12: PC and operand width; opcode SHALL be instr[DATA_W-1:DATA_W-4], operand S SHALL be instr[ADDR_W-1:0].
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mem_addr  out  ADDR_W  shared instruction/data bus address.
REQ-007 mem_read  out  1  read strobe.
REQ-008 mem_write  out  1  write strobe.
REQ-009 mem_wdata  out  DATA_W  write data; SHALL equal acc.
REQ-010 mem_rdata  in  DATA_W  read data; valid in the cycle mem_read=1 and mem_waitrequest=0.
REQ-011 mem_waitrequest  in  1  slave stall.
REQ-012 running  out  1  high in every state except HALT.
REQ-013 err  out  1  sticky; set on undefined opcode.
REQ-014 out_valid  out  1  one-cycle pulse per OUT instruction.
REQ-015 out_data  out  DATA_W  acc value captured by OUT.
REQ-016 pc  out  ADDR_W  current program counter.

Function
REQ-017 The FSM SHALL have states FETCH, DECODE, MEM, HALT; mem_read, mem_write and mem_addr SHALL be decoded from state and IR only.
REQ-018 FETCH: mem_read=1, mem_addr=pc; on transfer, IR<=mem_rdata, pc<=pc+1 modulo 2^ADDR_W, go to DECODE; while mem_waitrequest=1, hold.
REQ-019 While mem_waitrequest=1, mem_addr, mem_read, mem_write and mem_wdata SHALL stay stable and no architectural state SHALL change.
REQ-020 DECODE opcode 0000 LDA, 0001 STO, 0010 ADD, 0011 SUB SHALL go to MEM.
REQ-021 MEM: mem_addr=S; STO drives mem_write=1, others mem_read=1; on transfer LDA acc<=rdata, ADD acc<=acc+rdata, SUB acc<=acc-rdata (modulo 2^DATA_W), STO no acc change; go to FETCH.
REQ-022 DECODE 0100 JMP SHALL set pc<=S; go to FETCH.
REQ-023 DECODE 0101 JGE SHALL set pc<=S when acc as signed is >= 0, else pc unchanged; go to FETCH.
REQ-024 DECODE 0110 JNE SHALL set pc<=S when acc != 0, else pc unchanged; go to FETCH.
REQ-025 DECODE 1000 OUT SHALL assert out_valid for exactly the next cycle with out_data=acc; go to FETCH.
REQ-026 DECODE 1001 LDI SHALL set acc<=S zero-extended to DATA_W; go to FETCH.
REQ-027 DECODE 0111 STP SHALL go to HALT.
REQ-028 DECODE of opcodes 1010-1111 SHALL set err<=1 and go to HALT.
REQ-029 HALT SHALL be left only by rst; no bus strobes in HALT.
REQ-030 Latency with zero wait: DECODE-only instructions 2 cycles; LDA/STO/ADD/SUB 3 cycles; each waitrequest cycle adds one.
REQ-031 Outside DECODE->next-cycle of OUT, out_valid SHALL be 0; out_data SHALL hold last OUT value.

Reset
REQ-032 Reset SHALL set state=FETCH, pc=RESET_PC, acc=0, IR=0, err=0, out_valid=0, out_data=0, running=1.
REQ-033 rst asserted in any state, including mid-transfer under waitrequest, SHALL abandon the access; in the following cycle mem_write=0 and mem_read fetches RESET_PC.
REQ-034 rst SHALL take priority over all other events in the same cycle.

Verification
REQ-035 mem[0]=0x0010 LDA, mem[1]=0x2011 ADD, mem[2]=0x1012 STO, mem[3]=0x7000 STP, mem[0x10]=0x0005, mem[0x11]=0x0003 -> write 0x0008 to 0x012, running=0, pc=0x004, err=0.
REQ-036 waitrequest=1 for 3 cycles on first fetch -> mem_addr=0x000, mem_read=1 stable, pc unchanged; completion 3 cycles later.
REQ-037 LDI 0x800 then SUB of 0x1000 (acc=0xF800 negative), JGE 0x020 -> not taken, pc=next; acc=0x0000, JGE 0x020 -> taken, next fetch 0x020.
REQ-038 LDI 0xFFF, SUB of 0x0001 (acc=0x0FFE), OUT -> out_valid high one cycle, out_data=0x0FFE.
REQ-039 RESET_PC=0xFFF, mem[0xFFF]=0x9001 LDI -> next fetch at 0x000, acc=0x0001.
REQ-040 mem[0]=0xA000 -> err=1, running=0, no further strobes; rst during MEM with waitrequest=1 -> next cycle mem_write=0, fetch at RESET_PC, err=0.
